// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer for the multicycle core.
// Drives the 1-cycle synchronous instruction ROM, holds the PC, hands each
// fetched word to the core over valid/ready, applies branch/jump redirects,
// and time-shares the ROM with a debug/loader read port.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,
  output logic              fetch_fault
);

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_DATA     = 3'd1,
    S_HOLD     = 3'd2,
    S_DBG_REQ  = 3'd3,
    S_DBG_DATA = 3'd4,
    S_FAULT    = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        r_instr_valid;
  logic [31:0] r_dbg_rdata;
  logic        r_dbg_rvalid;
  logic        r_fetch_fault;
  logic        r_dbg_owed;
  logic        r_pend_vld;
  logic [31:0] r_pend_pc;

  logic [31:0] w_pc_nxt;
  logic [31:0] w_instr_nxt;
  logic [31:0] w_instr_pc_nxt;
  logic        w_instr_valid_nxt;
  logic [31:0] w_dbg_rdata_nxt;
  logic        w_dbg_rvalid_nxt;
  logic        w_fetch_fault_nxt;
  logic        w_dbg_owed_nxt;
  logic        w_pend_vld_nxt;
  logic [31:0] w_pend_pc_nxt;
  logic        w_dbg_gnt;
  logic [ADDR_W-1:0] w_rom_addr;

  logic        w_redir_ok;
  logic        w_core_state;
  logic        w_tgt_vld;
  logic [31:0] w_tgt_pc;
  logic        w_tgt_ok;

  // Redirects act immediately only in the core-owned states.
  assign w_core_state = (r_state == S_FETCH) || (r_state == S_DATA) ||
                        (r_state == S_HOLD);
  assign w_redir_ok   = (redirect_pc[1:0] == 2'b00);

  // Redirect to apply when the debug access finishes: a redirect arriving in
  // the final debug cycle overrides an older pending one.
  assign w_tgt_vld = redirect_valid | r_pend_vld;
  assign w_tgt_pc  = redirect_valid ? redirect_pc : r_pend_pc;
  assign w_tgt_ok  = (w_tgt_pc[1:0] == 2'b00);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, datapath next values, ROM address and debug grant.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_instr_nxt       = r_instr;
    w_instr_pc_nxt    = r_instr_pc;
    w_instr_valid_nxt = r_instr_valid;
    w_dbg_rdata_nxt   = r_dbg_rdata;
    w_dbg_rvalid_nxt  = 1'b0;
    w_fetch_fault_nxt = r_fetch_fault;
    w_dbg_owed_nxt    = r_dbg_owed;
    w_pend_vld_nxt    = r_pend_vld;
    w_pend_pc_nxt     = r_pend_pc;
    w_dbg_gnt         = 1'b0;
    w_rom_addr        = r_pc[ADDR_W-1:0];

    if (redirect_valid && w_core_state) begin
      // Redirect beats fetch, data capture and a simultaneous accept; any
      // word in flight from the ROM is simply never captured.
      w_pc_nxt          = redirect_pc;
      w_instr_valid_nxt = 1'b0;
      if (w_redir_ok) begin
        w_state_nxt = S_FETCH;
      end else begin
        w_fetch_fault_nxt = 1'b1;
        w_state_nxt       = S_FAULT;
      end
    end else begin
      case (r_state)
        S_FETCH: begin
          if (dbg_req && !r_dbg_owed) begin
            w_state_nxt = S_DBG_REQ;
          end else begin
            w_state_nxt = S_DATA;
          end
        end

        S_DATA: begin
          w_instr_nxt       = rom_data;
          w_instr_pc_nxt    = r_pc;
          w_instr_valid_nxt = 1'b1;
          w_dbg_owed_nxt    = 1'b0;
          w_state_nxt       = S_HOLD;
        end

        S_HOLD: begin
          if (instr_ready) begin
            w_instr_valid_nxt = 1'b0;
            w_pc_nxt          = r_pc + 32'd4;
            w_state_nxt       = S_FETCH;
          end
        end

        S_DBG_REQ: begin
          w_dbg_gnt  = 1'b1;
          w_rom_addr = dbg_addr;
          if (redirect_valid) begin
            w_pend_vld_nxt = 1'b1;
            w_pend_pc_nxt  = redirect_pc;
          end
          w_state_nxt = S_DBG_DATA;
        end

        S_DBG_DATA: begin
          w_dbg_rdata_nxt  = rom_data;
          w_dbg_rvalid_nxt = 1'b1;
          w_dbg_owed_nxt   = 1'b1;
          w_pend_vld_nxt   = 1'b0;
          w_state_nxt      = S_FETCH;
          // The deferred redirect lands as the FSM re-enters S_FETCH, with
          // the same alignment check as an immediate one.
          if (w_tgt_vld) begin
            w_pc_nxt = w_tgt_pc;
            if (!w_tgt_ok) begin
              w_fetch_fault_nxt = 1'b1;
              w_state_nxt       = S_FAULT;
            end
          end
        end

        S_FAULT: begin
          w_state_nxt = S_FAULT;
        end

        default: begin
          w_state_nxt = S_FETCH;
        end
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_dbg_rdata   <= '0;
      r_dbg_rvalid  <= 1'b0;
      r_fetch_fault <= 1'b0;
      r_dbg_owed    <= 1'b0;
      r_pend_vld    <= 1'b0;
      r_pend_pc     <= '0;
    end else begin
      r_pc          <= w_pc_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_pc    <= w_instr_pc_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_dbg_rdata   <= w_dbg_rdata_nxt;
      r_dbg_rvalid  <= w_dbg_rvalid_nxt;
      r_fetch_fault <= w_fetch_fault_nxt;
      r_dbg_owed    <= w_dbg_owed_nxt;
      r_pend_vld    <= w_pend_vld_nxt;
      r_pend_pc     <= w_pend_pc_nxt;
    end
  end

  assign rom_addr    = w_rom_addr;
  assign dbg_gnt     = w_dbg_gnt;
  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign dbg_rvalid  = r_dbg_rvalid;
  assign dbg_rdata   = r_dbg_rdata;
  assign fetch_fault = r_fetch_fault;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: behavioural ROM, transaction-level model of the
// expected instruction stream and debug reads, plus directed literal checks.
module tb_ifetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [13:0] rom_addr;
  logic [31:0] rom_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dbg_req;
  logic [13:0] dbg_addr;
  logic        dbg_gnt;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        fetch_fault;

  ifetch_ctrl #(.RESET_PC(32'h0000_0000), .ADDR_W(14)) dut (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .dbg_req(dbg_req), .dbg_addr(dbg_addr),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .fetch_fault(fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: one-cycle registered read, word index = addr[13:2].
  logic [31:0] rom [0:4095];
  always @(posedge clk) rom_data <= rom[rom_addr[13:2]];

  int total = 0;
  int bad   = 0;

  // Model state: next PC the core must be handed, hold tracking, debug timing.
  logic [31:0] m_pc;
  logic        m_hold;
  logic [31:0] m_prev_instr;
  logic [31:0] m_prev_pc;
  logic        m_bad_seen;
  int          m_cyc;
  int          m_dbg_due;
  logic [31:0] m_dbg_exp;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic exp_rv;
    if (!rst_n) begin
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_fault", 32'(fetch_fault), 32'd0);
      check("rst_rvalid", 32'(dbg_rvalid), 32'd0);
      check("rst_gnt", 32'(dbg_gnt), 32'd0);
      check("rst_addr", 32'(rom_addr), 32'd0);
      m_pc = 32'd0; m_hold = 1'b0; m_bad_seen = 1'b0;
      m_cyc = 0; m_dbg_due = -1;
      return;
    end
    if (m_hold) begin
      check("hold_valid", 32'(instr_valid), 32'd1);
      check("hold_instr", instr, m_prev_instr);
      check("hold_pc", instr_pc, m_prev_pc);
    end
    if (instr_valid) begin
      check("m_instr_pc", instr_pc, m_pc);
      check("m_instr", instr, rom[m_pc[13:2]]);
      check("m_rom_addr", 32'(rom_addr), 32'(m_pc[13:0]));
    end
    exp_rv = (m_cyc == m_dbg_due);
    check("m_rvalid", 32'(dbg_rvalid), 32'(exp_rv));
    if (dbg_rvalid) check("m_rdata", dbg_rdata, m_dbg_exp);
    if (fetch_fault) begin
      check("fault_cause", 32'(m_bad_seen), 32'd1);
      check("fault_novalid", 32'(instr_valid), 32'd0);
      check("fault_nognt", 32'(dbg_gnt), 32'd0);
    end
    if (dbg_gnt) begin
      check("gnt_req", 32'(dbg_req), 32'd1);
      check("gnt_addr", 32'(rom_addr), 32'(dbg_addr));
      m_dbg_due = m_cyc + 2;
      m_dbg_exp = rom[dbg_addr[13:2]];
    end
    m_hold       = instr_valid && !instr_ready && !redirect_valid;
    m_prev_instr = instr;
    m_prev_pc    = instr_pc;
    if (redirect_valid) begin
      m_pc = redirect_pc;
      if (redirect_pc[1:0] != 2'b00) m_bad_seen = 1'b1;
    end else if (instr_valid && instr_ready) begin
      m_pc = m_pc + 32'd4;
    end
    m_cyc++;
  endtask

  // One clock: model compare at the falling edge, then return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!instr_valid && n < 12) begin
      tick();
      n++;
    end
    check("wait_valid", 32'(instr_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ngr, nsince, nrv, last_v;
    for (int i = 0; i < 4096; i++) rom[i] = 32'hC0DE_0000 ^ (i * 32'h0001_0003);
    rom[0]     = 32'hff0100b7;
    rom[1]     = 32'hf0008093;
    rom[2]     = 32'h00208113;
    rom[9]     = 32'h00900293;
    rom[16]    = 32'h01000313;
    rom[12'hFFF] = 32'h0badf00d;

    rst_n = 1'b0; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    dbg_req = 1'b0; dbg_addr = '0;
    repeat (3) tick();
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    rst_n = 1'b1;

    // First-fetch latency and steady throughput.
    check("lat_c0", 32'(instr_valid), 32'd0);
    tick();
    check("lat_c1", 32'(instr_valid), 32'd0);
    tick();
    check("lat_c2", 32'(instr_valid), 32'd1);
    check("first_instr", instr, 32'hff0100b7);
    check("first_pc", instr_pc, 32'h0);
    tick(); tick();
    check("gap_c4", 32'(instr_valid), 32'd0);
    tick();
    check("second_valid", 32'(instr_valid), 32'd1);
    check("second_instr", instr, 32'hf0008093);
    check("second_pc", instr_pc, 32'h4);

    // Back-pressure in S_HOLD.
    instr_ready = 1'b0;
    repeat (5) tick();
    check("stall_valid", 32'(instr_valid), 32'd1);
    check("stall_instr", instr, 32'hf0008093);
    check("stall_pc", instr_pc, 32'h4);
    check("stall_addr", 32'(rom_addr), 32'h4);
    instr_ready = 1'b1;
    tick();
    check("step_addr", 32'(rom_addr), 32'h8);
    check("step_valid", 32'(instr_valid), 32'd0);

    // Redirect during S_DATA.
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h24;
    tick();
    redirect_valid = 1'b0;
    check("rd_data_valid", 32'(instr_valid), 32'd0);
    check("rd_data_addr", 32'(rom_addr), 32'h24);
    wait_valid();
    check("rd_data_pc", instr_pc, 32'h24);
    check("rd_data_instr", instr, 32'h00900293);

    // Redirect in S_HOLD together with instr_ready.
    redirect_valid = 1'b1; redirect_pc = 32'h24;
    tick();
    redirect_valid = 1'b0;
    check("rd_hold_valid", 32'(instr_valid), 32'd0);
    wait_valid();
    check("rd_hold_pc", instr_pc, 32'h24);

    // Debug read held continuously: grants alternate with instructions.
    dbg_req = 1'b1; dbg_addr = 14'h8;
    ngr = 0; nsince = 0; nrv = 0; last_v = 0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (dbg_gnt) begin
        if (ngr > 0) check("fair_alt", nsince, 1);
        ngr++;
        nsince = 0;
      end
      if (dbg_rvalid) begin
        nrv++;
        check("dbg_rdata_rom2", dbg_rdata, 32'h00208113);
      end
      if (instr_valid) begin
        nsince++;
        check("fair_gap_ok", 32'((k - last_v) <= 6), 32'd1);
        last_v = k;
      end
    end
    dbg_req = 1'b0;
    check("fair_grants", ngr, 3);
    check("fair_rvalids", nrv, 3);
    check("fair_end_pc", instr_pc, 32'h30);

    // Address wrap at the top of the ROM window.
    redirect_valid = 1'b1; redirect_pc = 32'h3FFC;
    tick();
    redirect_valid = 1'b0;
    wait_valid();
    check("wrap_pre_pc", instr_pc, 32'h3FFC);
    check("wrap_pre_instr", instr, 32'h0badf00d);
    tick();
    check("wrap_addr", 32'(rom_addr), 32'h0);
    wait_valid();
    check("wrap_pc", instr_pc, 32'h4000);
    check("wrap_instr", instr, 32'hff0100b7);

    // Redirect arriving during a debug access is deferred.
    dbg_req = 1'b1; dbg_addr = 14'h8;
    begin
      int n;
      n = 0;
      while (!dbg_gnt && n < 10) begin
        tick();
        n++;
      end
    end
    check("defer_gnt", 32'(dbg_gnt), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0; dbg_req = 1'b0;
    tick();
    check("defer_addr", 32'(rom_addr), 32'h40);
    check("defer_rvalid", 32'(dbg_rvalid), 32'd1);
    check("defer_rdata", dbg_rdata, 32'h00208113);
    wait_valid();
    check("defer_pc", instr_pc, 32'h40);
    check("defer_instr", instr, 32'h01000313);

    // Misaligned redirect: sticky fault, debug ignored.
    dbg_req = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h26;
    tick();
    redirect_valid = 1'b0;
    check("fault_set", 32'(fetch_fault), 32'd1);
    check("fault_valid", 32'(instr_valid), 32'd0);
    for (int k = 0; k < 6; k++) begin
      instr_ready = k[0];
      tick();
    end
    instr_ready = 1'b1;
    check("fault_sticky", 32'(fetch_fault), 32'd1);
    check("fault_valid2", 32'(instr_valid), 32'd0);
    check("fault_gnt", 32'(dbg_gnt), 32'd0);
    check("fault_addr", 32'(rom_addr), 32'h26);

    // Asynchronous reset mid-state.
    rst_n = 1'b0;
    #1;
    check("arst_fault", 32'(fetch_fault), 32'd0);
    check("arst_valid", 32'(instr_valid), 32'd0);
    check("arst_addr", 32'(rom_addr), 32'h0);
    check("arst_gnt", 32'(dbg_gnt), 32'd0);
    dbg_req = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    check("restart_valid", 32'(instr_valid), 32'd1);
    check("restart_pc", instr_pc, 32'h0);
    check("restart_instr", instr, 32'hff0100b7);
    tick();
    wait_valid();
    check("restart_pc2", instr_pc, 32'h4);
    rst_n = 1'b0;
    #1;
    check("arst2_instr", instr, 32'h0);
    check("arst2_pc", instr_pc, 32'h0);
    check("arst2_valid", 32'(instr_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
Instruction-fetch sequencer for the multicycle RISC-V core. It drives the synchronous instruction ROM, which has a 1-cycle registered read and a byte address (word = addr[13:2]). It holds the PC, presents each fetched instruction to the core through a valid/ready handshake, and applies branch/jump redirects. It also gives a debug/loader port fair, time-shared read access to the same ROM.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ADDR_W, 14, ROM byte-address width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
rom_addr  out  ADDR_W  ROM byte address (combinational from state/pc/dbg_addr)
rom_data  in  32  ROM read data, valid the cycle after rom_addr was driven
instr_valid  out  1  instr/instr_pc hold a valid instruction
instr  out  32  fetched instruction word
instr_pc  out  32  PC of instr
instr_ready  in  1  core accepts instr this cycle
redirect_valid  in  1  load new PC (taken branch/jump/trap)
redirect_pc  in  32  redirect target
dbg_req  in  1  debug read request, level, held until dbg_rvalid
dbg_addr  in  ADDR_W  debug byte address
dbg_gnt  out  1  debug access issued this cycle
dbg_rvalid  out  1  1-cycle pulse, dbg_rdata valid
dbg_rdata  out  32  debug read data
fetch_fault  out  1  sticky: misaligned redirect target

Behaviour:
- Registers: pc[31:0], state, instr, instr_pc, instr_valid, dbg_rdata, dbg_rvalid, fetch_fault, dbg_owed (fairness flag).
- Reset (async) values: state=S_FETCH, pc=RESET_PC, instr_valid=0, instr=0, instr_pc=0, dbg_rvalid=0, dbg_rdata=0, fetch_fault=0, dbg_owed=0. During reset, rom_addr=RESET_PC[ADDR_W-1:0] and dbg_gnt=0.
- rom_addr: dbg_addr in S_DBG_REQ; otherwise pc[ADDR_W-1:0]. Upper PC bits are truncated, so addresses wrap modulo 2^ADDR_W.
- States:
  - S_FETCH: if dbg_req && !dbg_owed, go to S_DBG_REQ. Otherwise drive the pc address and go to S_DATA.
  - S_DATA: instr<=rom_data, instr_pc<=pc, instr_valid<=1, dbg_owed<=0; go to S_HOLD.
  - S_HOLD: instr_valid=1. On instr_ready: instr_valid<=0, pc<=pc+4 (32-bit wrap), go to S_FETCH.
  - S_DBG_REQ: dbg_gnt=1 (combinational, this state only); go to S_DBG_DATA.
  - S_DBG_DATA: dbg_rdata<=rom_data, dbg_rvalid<=1 (deasserts the next cycle), dbg_owed<=1; go to S_FETCH.
  - S_FAULT: terminal until reset. instr_valid=0, no debug grants, rom_addr=pc[ADDR_W-1:0].
- Latency: first instr_valid rises 2 cycles after reset release (cycle 0 FETCH, cycle 1 DATA, cycle 2 HOLD). With instr_ready tied high, throughput is 1 instruction per 3 cycles.
- Redirect: redirect_valid has top priority in S_FETCH, S_DATA and S_HOLD.
  - If redirect_pc[1:0]==0: pc<=redirect_pc, instr_valid<=0, go to S_FETCH. Any in-flight rom_data is discarded.
  - Redirect wins over a simultaneous instr_ready, and no pc+4 is applied.
  - If redirect_pc[1:0]!=0: fetch_fault<=1, instr_valid<=0, pc<=redirect_pc, go to S_FAULT.
- Redirect during S_DBG_REQ/S_DBG_DATA: the debug access completes normally. The redirect is captured in a pending register (last value wins) and applied on entry to S_FETCH, with the same alignment check.
- Fairness: after one debug access, dbg_owed forces at least one completed instruction fetch (S_DATA) before the next grant. This prevents debug starvation of the core and vice versa.
- dbg_req is sampled only in S_FETCH. A request raised mid-fetch waits for the next S_FETCH.
- instr/instr_pc are stable while instr_valid=1 and instr_ready=0.

Test Plan:
- Reset release, ROM word0=32'hff0100b7, word1=32'hf0008093, instr_ready=1 → instr_valid first high in cycle 2 with instr=ff0100b7, instr_pc=0. The next valid comes 3 cycles later: instr=f0008093, instr_pc=4.
- instr_ready held 0 for 5 cycles in S_HOLD → instr and instr_pc unchanged, rom_addr=pc, pc not incremented. Ready then pulsed → pc advances by exactly 4.
- redirect_valid with redirect_pc=0x24 during S_DATA, and separately in S_HOLD together with instr_ready=1 → stale word dropped; next instr_pc=0x24, not 0x4.
- dbg_req=1, dbg_addr=0x8 held continuously while the core fetches → grants alternate: debug read, one instruction, debug read. dbg_rvalid pulses with dbg_rdata=ROM[2], and the core never stalls beyond 2 extra cycles per instruction.
- redirect_pc=0x26 → fetch_fault=1 next cycle and sticky, instr_valid=0, dbg_req ignored. Asserting rst_n=0 mid-state clears all outputs immediately; on release, fetch restarts at RESET_PC.
- pc=0x3FFC with ADDR_W=14, accept → pc=0x4000, rom_addr=0x0000, instr_pc=0x4000.
